// File: rtl/mem_load_unit_if.sv
// Load-unit bus bundle: pipeline load request, data-memory read port and completion status.
interface mem_load_unit_if;
    logic        i_ld_valid;
    logic        o_ld_ready;
    logic [31:0] i_addr;
    logic [2:0]  i_funct3;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_shifted_mem_data;
    logic        o_done;
    logic        o_misaligned;
    logic        o_timeout;

    // The load unit itself
    modport slave (
        input  i_ld_valid, i_addr, i_funct3, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_ld_ready, o_mem_req, o_mem_addr, o_shifted_mem_data,
               o_done, o_misaligned, o_timeout
    );

    // Pipeline / memory side driving the load unit
    modport master (
        output i_ld_valid, i_addr, i_funct3, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_ld_ready, o_mem_req, o_mem_addr, o_shifted_mem_data,
               o_done, o_misaligned, o_timeout
    );
endinterface

// File: rtl/mem_load_unit.sv
// mem_load_unit: accepts one load at a time, issues a word-aligned memory read,
// extracts/extends the addressed byte/half/word and pulses o_done.
// Optional abort-on-timeout is enabled by defining LOAD_TIMEOUT_EN.
module mem_load_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mem_load_unit_if.slave bus
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e      state_q;
    logic        ready_q;
    logic        req_q;
    logic [31:0] mem_addr_q;
    logic [31:0] data_q;
    logic        done_q;
    logic        mis_q;
    logic        to_q;
    logic [1:0]  lane_q;
    logic [2:0]  f3_q;

    logic        bad_c;
    logic        timeout_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] result_c;

    // Request is misaligned for its size, or funct3 is not a load encoding
    always_comb begin
        bad_c = 1'b1;
        case (bus.i_funct3)
            3'b000, 3'b100: bad_c = 1'b0;
            3'b001, 3'b101: bad_c = bus.i_addr[0];
            3'b010:         bad_c = |bus.i_addr[1:0];
            default:        bad_c = 1'b1;
        endcase
    end

    // Lane extraction and sign/zero extension of the returned word
    always_comb begin
        byte_c = bus.i_mem_rdata[7:0];
        case (lane_q)
            2'd0:    byte_c = bus.i_mem_rdata[7:0];
            2'd1:    byte_c = bus.i_mem_rdata[15:8];
            2'd2:    byte_c = bus.i_mem_rdata[23:16];
            default: byte_c = bus.i_mem_rdata[31:24];
        endcase
        half_c = lane_q[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
        case (f3_q)
            3'b000:  result_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  result_c = {24'h000000, byte_c};
            3'b001:  result_c = {{16{half_c[15]}}, half_c};
            3'b101:  result_c = {16'h0000, half_c};
            default: result_c = bus.i_mem_rdata;
        endcase
    end

`ifdef LOAD_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    // Cycles spent in REQ/WAIT; held at zero while idle so it restarts on entry to REQ
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else if (state_q == S_REQ || state_q == S_WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout_c = (state_q == S_REQ || state_q == S_WAIT) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^CNT_W'(TIMEOUT_CYCLES);
    assign timeout_c          = 1'b0;
`endif

    // Load FSM with registered handshake, memory request and completion outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            req_q      <= 1'b0;
            mem_addr_q <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
            to_q       <= 1'b0;
            lane_q     <= '0;
            f3_q       <= '0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            to_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_ld_valid && ready_q) begin
                        ready_q <= 1'b0;
                        lane_q  <= bus.i_addr[1:0];
                        f3_q    <= bus.i_funct3;
                        if (bad_c) begin
                            state_q <= S_ERR;
                            done_q  <= 1'b1;
                            mis_q   <= 1'b1;
                            data_q  <= '0;
                        end else begin
                            state_q    <= S_REQ;
                            req_q      <= 1'b1;
                            mem_addr_q <= {bus.i_addr[31:2], 2'b00};
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (timeout_c) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        to_q    <= 1'b1;
                        data_q  <= '0;
                    end else if (bus.i_mem_gnt) begin
                        state_q <= S_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // A response arriving in the abort cycle still completes normally
                    if (bus.i_mem_rvalid) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        data_q  <= result_c;
                    end else if (timeout_c) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        to_q    <= 1'b1;
                        data_q  <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ld_ready         = ready_q;
    assign bus.o_mem_req          = req_q;
    assign bus.o_mem_addr         = mem_addr_q;
    assign bus.o_shifted_mem_data = data_q;
    assign bus.o_done             = done_q;
    assign bus.o_misaligned       = mis_q;
    assign bus.o_timeout          = to_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Bench for mem_load_unit: directed loads with a cycle-scheduled completion model
// and a per-cycle compare process. Define LOAD_TIMEOUT_EN to exercise the abort path.
module tb_mem_load_unit;

`ifdef LOAD_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 255;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        mis;
        logic        to;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] word;
        int          gd;
        int          rd;
        logic [31:0] lit;
    } vec_t;

    logic i_clk;
    logic i_rst;
    mem_load_unit_if bus();

    mem_load_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          chk_en   = 0;
    exp_t        expq[$];
    logic [31:0] exp_data = '0;
    int          busy_lo  = 1, busy_hi = 0;
    int          req_lo   = 1, req_hi  = 0;
    logic [31:0] req_addr = '0;
    vec_t        vecs[16];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Load size in bytes from funct3; illegal encodings and unaligned addresses are errors
    function automatic logic model_mis(input logic [31:0] a, input logic [2:0] f3);
        int sz;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        sz = 1 << f3[1:0];
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    // Shift the addressed bytes down, truncate to size, subtract 2^bits when signed and negative
    function automatic logic [31:0] model_ld(input logic [31:0] a, input logic [2:0] f3,
                                             input logic [31:0] w);
        int    sz;
        int    bits;
        longint v;
        sz   = 1 << f3[1:0];
        bits = 8 * sz;
        v    = longint'(w >> (8 * int'(a[1:0])));
        v    = v % (longint'(1) << bits);
        if (!f3[2] && sz < 4 && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    // Per-cycle comparison of every output against the scheduled model
    always @(negedge i_clk) begin : cmp
        logic ed, em, et, er, ebusy;
        if (chk_en) begin
            ed = 1'b0; em = 1'b0; et = 1'b0;
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                ed       = 1'b1;
                em       = expq[0].mis;
                et       = expq[0].to;
                exp_data = expq[0].data;
                expq.delete(0);
            end
            er    = (cyc >= req_lo) && (cyc <= req_hi);
            ebusy = (cyc >= busy_lo) && (cyc <= busy_hi);
            check("done",       32'(bus.o_done),         32'(ed));
            check("misaligned", 32'(bus.o_misaligned),   32'(em));
            check("timeout",    32'(bus.o_timeout),      32'(et));
            check("data",       bus.o_shifted_mem_data,  exp_data);
            check("mem_req",    32'(bus.o_mem_req),      32'(er));
            check("ld_ready",   32'(bus.o_ld_ready),     32'(!ebusy));
            if (er) check("mem_addr", bus.o_mem_addr, req_addr);
        end
    end

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] word,
                           input int gd, input int rd, input logic [31:0] lit);
        int   acc, gc, rc;
        exp_t e;
        bus.i_ld_valid = 1'b1;
        bus.i_addr     = addr;
        bus.i_funct3   = f3;
        @(posedge i_clk); #1;
        acc            = cyc;
        bus.i_ld_valid = 1'b0;
        bus.i_addr     = ~addr;
        bus.i_funct3   = ~f3;
        if (model_mis(addr, f3)) begin
            e = '{cyc: acc, data: 32'h0, mis: 1'b1, to: 1'b0};
            expq.push_back(e);
            busy_lo = acc; busy_hi = acc;
            check("err_lit_data", bus.o_shifted_mem_data, lit);
            check("err_lit_done", 32'(bus.o_done), 32'd1);
            @(posedge i_clk); #1;
        end else begin
            gc = acc + gd;
            rc = gc + 1 + rd;
            e  = '{cyc: rc + 1, data: model_ld(addr, f3, word), mis: 1'b0, to: 1'b0};
            expq.push_back(e);
            busy_lo  = acc; busy_hi = rc;
            req_lo   = acc; req_hi  = gc;
            req_addr = {addr[31:2], 2'b00};
            // Stray response while still requesting must be ignored
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = word ^ 32'h5A5A_5A5A;
            repeat (gd) begin @(posedge i_clk); #1; end
            bus.i_mem_gnt = 1'b1;
            @(posedge i_clk); #1;
            bus.i_mem_gnt    = 1'b0;
            bus.i_mem_rvalid = 1'b0;
            repeat (rd) begin @(posedge i_clk); #1; end
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = word;
            @(posedge i_clk); #1;
            bus.i_mem_rvalid = 1'b0;
            bus.i_mem_rdata  = '0;
            check("lit_data", bus.o_shifted_mem_data, lit);
            check("lit_done", 32'(bus.o_done), 32'd1);
        end
    endtask

`ifdef LOAD_TIMEOUT_EN
    task automatic do_timeout(input logic [31:0] addr, input bit grant);
        int   acc;
        exp_t e;
        bus.i_ld_valid = 1'b1;
        bus.i_addr     = addr;
        bus.i_funct3   = 3'b010;
        @(posedge i_clk); #1;
        acc            = cyc;
        bus.i_ld_valid = 1'b0;
        e = '{cyc: acc + int'(TO), data: 32'h0, mis: 1'b0, to: 1'b1};
        expq.push_back(e);
        busy_lo  = acc; busy_hi = acc + int'(TO) - 1;
        req_lo   = acc; req_hi  = grant ? acc : acc + int'(TO) - 1;
        req_addr = {addr[31:2], 2'b00};
        if (grant) begin
            bus.i_mem_gnt = 1'b1;
            @(posedge i_clk); #1;
            bus.i_mem_gnt = 1'b0;
            repeat (TO - 1) begin @(posedge i_clk); #1; end
        end else begin
            repeat (TO) begin @(posedge i_clk); #1; end
        end
        check("to_lit_timeout", 32'(bus.o_timeout), 32'd1);
        check("to_lit_data", bus.o_shifted_mem_data, 32'h0);
        check("to_lit_ready", 32'(bus.o_ld_ready), 32'd1);
    endtask
`endif

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        vecs = '{
            '{32'h0000_0103, 3'b000, 32'h80AB_CDEF, 0, 0, 32'hFFFF_FF80},
            '{32'h0000_0202, 3'b101, 32'h9234_5678, 0, 0, 32'h0000_9234},
            '{32'h0000_0202, 3'b001, 32'h9234_5678, 0, 0, 32'hFFFF_9234},
            '{32'h0000_0204, 3'b010, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF},
            '{32'h0000_0006, 3'b010, 32'h1111_1111, 0, 0, 32'h0000_0000},
            '{32'h0000_0010, 3'b011, 32'h2222_2222, 0, 0, 32'h0000_0000},
            '{32'h0000_0101, 3'b100, 32'h80AB_CDEF, 1, 0, 32'h0000_00CD},
            '{32'h0000_0100, 3'b000, 32'h1234_567F, 0, 1, 32'h0000_007F},
            '{32'h0000_0302, 3'b000, 32'hA5B6_C7D8, 2, 1, 32'hFFFF_FFB6},
            '{32'h0000_0301, 3'b001, 32'h3333_3333, 0, 0, 32'h0000_0000},
            '{32'h0000_0300, 3'b010, 32'h0123_4567, 5, 0, 32'h0123_4567},
            '{32'h0000_0402, 3'b100, 32'hA5B6_C7D8, 1, 3, 32'h0000_00B6},
            '{32'h0000_0007, 3'b110, 32'h4444_4444, 0, 0, 32'h0000_0000},
            '{32'h0000_0000, 3'b101, 32'h0000_FFFF, 0, 0, 32'h0000_FFFF},
            '{32'h0000_0103, 3'b101, 32'h5555_5555, 0, 0, 32'h0000_0000},
            '{32'h0000_0008, 3'b111, 32'h6666_6666, 0, 0, 32'h0000_0000}
        };

        i_rst            = 1'b0;
        bus.i_ld_valid   = 1'b0;
        bus.i_addr       = '0;
        bus.i_funct3     = '0;
        bus.i_mem_gnt    = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;

        // Outputs while held in reset
        #3;
        check("rst_ready", 32'(bus.o_ld_ready), 32'd0);
        check("rst_req",   32'(bus.o_mem_req),  32'd0);
        check("rst_addr",  bus.o_mem_addr,      32'd0);
        check("rst_data",  bus.o_shifted_mem_data, 32'd0);
        check("rst_done",  32'(bus.o_done),     32'd0);
        #9 i_rst = 1'b1;
        @(posedge i_clk); #1;
        check("ready_after_rst", 32'(bus.o_ld_ready), 32'd1);
        chk_en = 1'b1;

        foreach (vecs[i])
            do_load(vecs[i].addr, vecs[i].f3, vecs[i].word, vecs[i].gd, vecs[i].rd, vecs[i].lit);

`ifndef LOAD_TIMEOUT_EN
        // No abort without the timeout option: a very late response still completes
        do_load(32'h0000_0500, 3'b010, 32'hCAFE_F00D, 3, 300, 32'hCAFE_F00D);
`endif

        // Reset in WAIT abandons the load; a following response is ignored
        bus.i_ld_valid = 1'b1;
        bus.i_addr     = 32'h0000_0600;
        bus.i_funct3   = 3'b010;
        @(posedge i_clk); #1;
        bus.i_ld_valid = 1'b0;
        req_lo = cyc; req_hi = cyc; req_addr = 32'h0000_0600;
        busy_lo = cyc; busy_hi = cyc + 100000;
        bus.i_mem_gnt = 1'b1;
        @(posedge i_clk); #1;
        bus.i_mem_gnt = 1'b0;
        chk_en = 1'b0;
        #1 i_rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.o_ld_ready), 32'd0);
        check("mid_rst_req",   32'(bus.o_mem_req),  32'd0);
        check("mid_rst_addr",  bus.o_mem_addr,      32'd0);
        check("mid_rst_data",  bus.o_shifted_mem_data, 32'd0);
        check("mid_rst_done",  32'(bus.o_done),     32'd0);
        check("mid_rst_mis",   32'(bus.o_misaligned), 32'd0);
        check("mid_rst_to",    32'(bus.o_timeout),  32'd0);
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h7777_7777;
        @(posedge i_clk); #2;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        busy_lo = 1; busy_hi = 0;
        req_lo  = 1; req_hi  = 0;
        exp_data = '0;
        check("post_rst_ready", 32'(bus.o_ld_ready), 32'd1);
        check("post_rst_queue", 32'(expq.size()), 32'd0);
        chk_en = 1'b1;
        repeat (2) begin @(posedge i_clk); #1; end
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
        do_load(32'h0000_0606, 3'b001, 32'h8001_0000, 0, 0, 32'hFFFF_8001);

`ifdef LOAD_TIMEOUT_EN
        do_timeout(32'h0000_0700, 1'b1);
        do_timeout(32'h0000_0704, 1'b0);
        // Response in the final allowed cycle wins over the abort
        do_load(32'h0000_0708, 3'b010, 32'h1357_9BDF, 0, int'(TO) - 2, 32'h1357_9BDF);
`endif

        do_load(32'h0000_0800, 3'b000, 32'h0000_0042, 0, 0, 32'h0000_0042);
        repeat (3) begin @(posedge i_clk); #1; end
        check("queue_empty", 32'(expq.size()), 32'd0);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
